// File: rtl/reg_file_wb.sv
// reg_file_wb
//   General-purpose register file: 2**ADDR_W entries of DATA_W bits. It has
//   two combinational read ports with write-to-read bypass, one primary write
//   port and one secondary write port aimed at a fixed register (SEC_REG).
//   The secondary port carries the multiply high word or divide remainder.
//
// Ports
//   clk       in   system clock; all state updates on the rising edge
//   rst       in   synchronous active-high reset; clears the array and
//                  wr_count, and forces both read ports to 0
//   rd_addr1  in   read port 1 index
//   rd_addr2  in   read port 2 index
//   rd_data1  out  read port 1 data (combinational, bypassed)
//   rd_data2  out  read port 2 data (combinational, bypassed)
//   wr_en     in   primary write enable
//   wr_addr   in   primary write index (from the destination select stage)
//   wr_data   in   primary write data
//   wr2_en    in   secondary write enable (target fixed at SEC_REG)
//   wr2_data  in   secondary write data
//   wr_count  out  saturating count of edges that committed any write
//
// Handshake: there is no valid/ready flow control. A write enable sampled
// high on a rising edge with rst low always commits on that edge.
module reg_file_wb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int SEC_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr2_en,
  input  logic [DATA_W-1:0] wr2_data,
  output logic [7:0]        wr_count
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SEC_ADDR = ADDR_W'(SEC_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [7:0]        wr_count_q;
  logic [7:0]        wr_count_d;

  // Next-state of the array. The secondary write is applied first so that a
  // primary write to SEC_REG on the same edge overrides it.
  always_comb begin
    regs_d = regs_q;
    if (wr2_en) begin
      regs_d[SEC_ADDR] = wr2_data;
    end
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // A dual write counts as one committed cycle. The counter holds at 255.
  always_comb begin
    wr_count_d = wr_count_q;
    if ((wr_en || wr2_en) && (wr_count_q != 8'hFF)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read-port bypass uses the same priority as the write collision rule.
  // As a result, the value read always matches the value the edge will store.
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    if (rst) begin
      rd_data1 = '0;
    end else if (wr_en && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
    end else if (wr2_en && (rd_addr1 == SEC_ADDR)) begin
      rd_data1 = wr2_data;
    end
  end

  always_comb begin
    rd_data2 = regs_q[rd_addr2];
    if (rst) begin
      rd_data2 = '0;
    end else if (wr_en && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_data;
    end else if (wr2_en && (rd_addr2 == SEC_ADDR)) begin
      rd_data2 = wr2_data;
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb. It covers reset, basic and bypassed writes,
// the dual write, the collision rule, reset dropping a write, and counter
// saturation.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr2_en;
  logic [15:0] wr2_data;
  logic [7:0]  wr_count;

  int n_checks;
  int n_pass;

  reg_file_wb #(.DATA_W(16), .ADDR_W(4), .SEC_REG(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr2_en   (wr2_en),
    .wr2_data (wr2_data),
    .wr_count (wr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge. Outputs are sampled 1 ns after
  // that, which keeps both well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en    = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 16'h0000;
    wr2_en   = 1'b0;
    wr2_data = 16'h0000;
  endtask

  task automatic read_both(input logic [3:0] a1, input logic [3:0] a2);
    rd_addr1 = a1;
    rd_addr2 = a2;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    rd_addr1 = 4'd0;
    rd_addr2 = 4'd0;
    idle_inputs();
    // Reset, with a write held on the inputs the whole time.
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 16'hBEEF;
    tick();
    tick();
    read_both(4'd3, 4'd3);
    check_eq("rst_force_rd1", rd_data1, 16'h0000);
    check_eq("rst_force_rd2", rd_data2, 16'h0000);
    idle_inputs();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      read_both(4'(i), 4'(15 - i));
      check_eq($sformatf("rst_sweep_rd1_%0d", i), rd_data1, 16'h0000);
      check_eq($sformatf("rst_sweep_rd2_%0d", i), rd_data2, 16'h0000);
    end
    check_eq("rst_wr_count", {8'h00, wr_count}, 16'h0000);

    // Basic write and read.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    tick();
    idle_inputs();
    read_both(4'd5, 4'd6);
    check_eq("basic_r5", rd_data1, 16'h1234);
    check_eq("basic_r6", rd_data2, 16'h0000);
    check_eq("basic_count", {8'h00, wr_count}, 16'h0001);

    // Bypass read before the edge, then the stored value after it.
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hA5A5;
    read_both(4'd9, 4'd9);
    check_eq("bypass_rd1", rd_data1, 16'hA5A5);
    check_eq("bypass_rd2", rd_data2, 16'hA5A5);
    tick();
    idle_inputs();
    read_both(4'd9, 4'd5);
    check_eq("bypass_stored_r9", rd_data1, 16'hA5A5);
    check_eq("bypass_keep_r5", rd_data2, 16'h1234);
    check_eq("bypass_count", {8'h00, wr_count}, 16'h0002);

    // Dual write counts once.
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h00FF;
    wr2_en = 1'b1; wr2_data = 16'h7F00;
    tick();
    idle_inputs();
    read_both(4'd4, 4'd0);
    check_eq("dual_r4", rd_data1, 16'h00FF);
    check_eq("dual_r0", rd_data2, 16'h7F00);
    check_eq("dual_count", {8'h00, wr_count}, 16'h0003);

    // Secondary port bypass while the primary writes elsewhere.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0707;
    wr2_en = 1'b1; wr2_data = 16'h5A5A;
    read_both(4'd0, 4'd7);
    check_eq("wr2_bypass_r0", rd_data1, 16'h5A5A);
    check_eq("wr2_bypass_r7", rd_data2, 16'h0707);
    tick();
    idle_inputs();
    read_both(4'd0, 4'd7);
    check_eq("wr2_stored_r0", rd_data1, 16'h5A5A);
    check_eq("wr2_stored_r7", rd_data2, 16'h0707);
    check_eq("wr2_count", {8'h00, wr_count}, 16'h0005 - 16'h0001);

    // Collision: the primary write wins on SEC_REG.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1111;
    wr2_en = 1'b1; wr2_data = 16'h2222;
    read_both(4'd0, 4'd4);
    check_eq("coll_bypass_r0", rd_data1, 16'h1111);
    check_eq("coll_other_r4", rd_data2, 16'h00FF);
    tick();
    idle_inputs();
    read_both(4'd0, 4'd0);
    check_eq("coll_stored_r0", rd_data1, 16'h1111);
    check_eq("coll_count", {8'h00, wr_count}, 16'h0005);

    // Reset drops a write presented on the same edge.
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h3333;
    read_both(4'd0, 4'd4);
    check_eq("rstw_force_rd1", rd_data1, 16'h0000);
    tick();
    rst = 1'b0;
    idle_inputs();
    read_both(4'd0, 4'd4);
    check_eq("rstw_r0", rd_data1, 16'h0000);
    check_eq("rstw_r4", rd_data2, 16'h0000);
    check_eq("rstw_count", {8'h00, wr_count}, 16'h0000);

    // Saturation: 260 consecutive write cycles to addresses i%16 with data i.
    for (int i = 0; i < 260; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i % 16);
      wr_data = 16'(i);
      tick();
      if (i == 253) check_eq("sat_count_254", {8'h00, wr_count}, 16'h00FE);
      if (i == 254) check_eq("sat_count_255", {8'h00, wr_count}, 16'h00FF);
    end
    idle_inputs();
    read_both(4'd3, 4'd15);
    check_eq("sat_count_hold", {8'h00, wr_count}, 16'h00FF);
    check_eq("sat_r3", rd_data1, 16'h0103);
    check_eq("sat_r15", rd_data2, 16'h00FF);
    tick();
    check_eq("sat_idle_hold", {8'h00, wr_count}, 16'h00FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 16-entry x 16-bit general register file. It sits directly downstream of the register-destination select stage and consumes its 4-bit destination address as the primary write address.
- Provides two read ports for decode/operand fetch.
- Provides a secondary fixed-target write port, used to write the multiply high word / divide remainder alongside the primary result.
- Includes write-to-read bypass, so a write and a read of the same register in one cycle return the new value.

Parameters:
- DATA_W, 16, register and data width in bits
- ADDR_W, 4, register address width; depth = 2**ADDR_W
- SEC_REG, 0, index of the register targeted by the secondary write port

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rd_addr1  input  ADDR_W  read port 1 register index
- rd_addr2  input  ADDR_W  read port 2 register index
- rd_data1  output  DATA_W  read port 1 data (combinational)
- rd_data2  output  DATA_W  read port 2 data (combinational)
- wr_en  input  1  primary write enable
- wr_addr  input  ADDR_W  primary write index (from destination select stage)
- wr_data  input  DATA_W  primary write data
- wr2_en  input  1  secondary write enable (target fixed at SEC_REG)
- wr2_data  input  DATA_W  secondary write data
- wr_count  output  8  count of committed write cycles, saturating, for debug

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - on a rising clk edge with rst=1, all 2**ADDR_W registers are cleared to 0 and wr_count is cleared to 0;
  - wr_en/wr2_en are ignored on that edge;
  - while rst=1, rd_data1 and rd_data2 are forced to 0 and bypass is disabled.
- Writes (rst=0):
  - wr_en=1 commits wr_data to reg[wr_addr] at the rising edge;
  - wr2_en=1 commits wr2_data to reg[SEC_REG] at the same edge;
  - single-cycle latency: the value is visible from the array on the cycle after the edge.
- Write collision: wr_en=1, wr2_en=1 and wr_addr==SEC_REG in the same cycle -> the primary write wins, reg[SEC_REG] <= wr_data, and wr2_data is discarded.
- Reads: combinational, no clock latency, with bypass priority per port (checked for each port independently):
  1. rst=1 -> 0;
  2. wr_en=1 and rd_addrN==wr_addr -> wr_data;
  3. wr2_en=1 and rd_addrN==SEC_REG -> wr2_data;
  4. otherwise reg[rd_addrN].
  - Bypass order matches collision priority, so the value read always equals the value that will be stored.
- No hardwired-zero register; every index, including 0, is writable.
- wr_count:
  - increments by 1 on each edge where rst=0 and (wr_en or wr2_en)=1;
  - a dual write counts once;
  - saturates at 255, with no wrap.
- Address width: rd_addr/wr_addr are exactly ADDR_W bits, so every encoding is a valid register and there is no out-of-range case.
- Reset mid-operation: a write presented on the same edge as rst=1 is dropped; the register reads 0 afterwards.
- No X propagation: every output is driven for all input combinations; no latches.

Test Plan:
- Reset then read all: assert rst 2 cycles, sweep rd_addr1/rd_addr2 over 0..15 -> all reads 0x0000, wr_count=0; while rst=1, rd_data forced 0 even if wr_en=1, wr_addr=3, wr_data=0xBEEF.
- Basic write/read: wr_en=1, wr_addr=5, wr_data=0x1234, one edge, then rd_addr1=5 -> 0x1234; rd_addr2=6 -> 0x0000; wr_count=1.
- Bypass: same cycle wr_en=1, wr_addr=9, wr_data=0xA5A5, rd_addr1=9, rd_addr2=9 -> both read 0xA5A5 before the edge; after the edge, the array holds 0xA5A5.
- Dual write: wr_en=1, wr_addr=4, wr_data=0x00FF with wr2_en=1, wr2_data=0x7F00 -> after the edge, R4=0x00FF and R0=0x7F00; wr_count increments by exactly 1.
- Collision: wr_en=1, wr_addr=0, wr_data=0x1111, wr2_en=1, wr2_data=0x2222 -> rd_addr1=0 bypass reads 0x1111 and R0=0x1111 after the edge. Follow with reset asserted together with wr_en=1, wr_addr=0, wr_data=0x3333 -> R0 reads 0x0000 after the edge.
- Counter saturation: 260 consecutive write cycles -> wr_count reaches 255 and holds at 255.
